// File: rtl/console_pkg.sv
// Shared definitions for the text console sequencer: default geometry,
// fill character, control codes, state encodings and the cell-address helper.
package console_pkg;

   localparam int         COLS_DEF  = 80;
   localparam int         ROWS_DEF  = 30;
   localparam logic [7:0] ATTR_DEF  = 8'h00;
   localparam logic [7:0] BLANK_DEF = 8'h20;

   localparam logic [7:0] CH_BS = 8'h08;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_FF = 8'h0C;
   localparam logic [7:0] CH_CR = 8'h0D;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_SCR_RD,
      S_SCR_WR,
      S_SCR_FILL,
      S_CLEAR
   } con_state_t;

   typedef enum logic [1:0] {
      X_IDLE,
      X_REQ,
      X_GAP
   } xfer_state_t;

   // Linear cell index row*cols+col, 12-bit unsigned (max 2399 for 80x30).
   function automatic logic [11:0] cell_addr(input logic [4:0] row,
                                             input logic [6:0] col,
                                             input int cols);
      return 12'(row) * 12'(cols) + 12'(col);
   endfunction

endpackage

// File: rtl/console_bus_xfer.sv
// Single-transaction bus master for the video card slave port.
//   clk, reset      : clock, async active-high reset
//   start           : launch one transaction (accepted only when idle)
//   we, addr, wdata : transaction attributes, captured on start
//   done            : one-cycle pulse once ACK has gone low again
//   rdata           : DAT_I[15:0] captured in the cycle ACK=1 is sampled
//   STB/WE/ADDR/DAT_O/DAT_I/ACK : card bus
// FSM states:
//   X_IDLE | no transaction, waiting for start
//   X_REQ  | STB high, waiting for ACK=1
//   X_GAP  | STB dropped, waiting for the lagging ACK to return low
module console_bus_xfer
   import console_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        we,
   input  logic [11:0] addr,
   input  logic [15:0] wdata,
   output logic        done,
   output logic [15:0] rdata,
   output logic        STB,
   output logic        WE,
   output logic [31:0] ADDR,
   output logic [31:0] DAT_O,
   input  logic [31:0] DAT_I,
   input  logic        ACK
);

   xfer_state_t xst_q, xst_d;
   logic        stb_q, stb_d;
   logic        we_q, we_d;
   logic [11:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic [15:0] rdata_q, rdata_d;
   logic        dat_i_unused;

   // The card only drives the low half-word.
   assign dat_i_unused = ^DAT_I[31:16];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xst_q   <= X_IDLE;
         stb_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         xst_q   <= xst_d;
         stb_q   <= stb_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      xst_d   = xst_q;
      stb_d   = stb_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (xst_q)
         X_IDLE: begin
            if (start) begin
               stb_d   = 1'b1;
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               xst_d   = X_REQ;
            end
         end
         X_REQ: begin
            if (ACK) begin
               stb_d = 1'b0;
               we_d  = 1'b0;
               if (!we_q) begin
                  rdata_d = DAT_I[15:0];
               end
               xst_d = X_GAP;
            end
         end
         X_GAP: begin
            if (!ACK) begin
               xst_d = X_IDLE;
            end
         end
         default: xst_d = X_IDLE;
      endcase
   end

   always_comb begin
      STB   = stb_q;
      WE    = we_q;
      ADDR  = {20'b0, addr_q};
      DAT_O = {16'b0, wdata_q};
      rdata = rdata_q;
      done  = (xst_q == X_GAP) && !ACK;
   end

endmodule

// File: rtl/text_console_ctrl.sv
// Terminal-style sequencer for the 80x30 text-mode card. Consumes bytes over
// ch_valid/ch_ready, keeps the cursor, and drives writes/scroll/clear into the
// card's character memory through console_bus_xfer.
//   clk, reset         : clock, async active-high reset
//   ch_valid/ch_data   : byte input; ch_ready high only in IDLE
//   STB/WE/ADDR/DAT_O  : card bus outputs; DAT_I/ACK card bus inputs
//   cur_col/cur_row    : cursor, updated only when a sequence completes
//   busy               : ~ch_ready
// state      | meaning
// S_IDLE     | accept and decode one byte
// S_WRITE    | write char_q at idx_q (printable or backspace erase)
// S_SCR_RD   | scroll: read cell idx_q
// S_SCR_WR   | scroll: write the read word to idx_q-COLS
// S_SCR_FILL | scroll: blank the last row, cell idx_q
// S_CLEAR    | clear screen, cell idx_q
module text_console_ctrl
   import console_pkg::*;
#(
   parameter int         COLS  = COLS_DEF,
   parameter int         ROWS  = ROWS_DEF,
   parameter logic [7:0] ATTR  = ATTR_DEF,
   parameter logic [7:0] BLANK = BLANK_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ch_valid,
   input  logic [7:0]  ch_data,
   output logic        ch_ready,
   output logic        STB,
   output logic        WE,
   output logic [31:0] ADDR,
   output logic [31:0] DAT_O,
   input  logic [31:0] DAT_I,
   input  logic        ACK,
   output logic [6:0]  cur_col,
   output logic [4:0]  cur_row,
   output logic        busy
);

   localparam logic [6:0]  LAST_COL      = 7'(COLS - 1);
   localparam logic [4:0]  LAST_ROW      = 5'(ROWS - 1);
   localparam logic [11:0] ROW1_BASE     = 12'(COLS);
   localparam logic [11:0] LAST_ROW_BASE = 12'((ROWS - 1) * COLS);
   localparam logic [11:0] LAST_CELL     = 12'(COLS * ROWS - 1);

   con_state_t  state_q, state_d;
   logic [6:0]  col_q, col_d;
   logic [4:0]  row_q, row_d;
   logic [11:0] idx_q, idx_d;
   logic [7:0]  char_q, char_d;
   logic        bs_q, bs_d;
   logic        issued_q, issued_d;

   logic        xfer_start;
   logic        xfer_we;
   logic [11:0] xfer_addr;
   logic [15:0] xfer_wdata;
   logic        xfer_done;
   logic [15:0] xfer_rdata;

   console_bus_xfer u_xfer (
      .clk   (clk),
      .reset (reset),
      .start (xfer_start),
      .we    (xfer_we),
      .addr  (xfer_addr),
      .wdata (xfer_wdata),
      .done  (xfer_done),
      .rdata (xfer_rdata),
      .STB   (STB),
      .WE    (WE),
      .ADDR  (ADDR),
      .DAT_O (DAT_O),
      .DAT_I (DAT_I),
      .ACK   (ACK)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         col_q    <= '0;
         row_q    <= '0;
         idx_q    <= '0;
         char_q   <= '0;
         bs_q     <= 1'b0;
         issued_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         idx_q    <= idx_d;
         char_q   <= char_d;
         bs_q     <= bs_d;
         issued_q <= issued_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      idx_d    = idx_q;
      char_d   = char_q;
      bs_d     = bs_q;
      // One transaction per visit of a bus state; re-armed when it completes.
      issued_d = issued_q;
      if (xfer_start) issued_d = 1'b1;
      if (xfer_done)  issued_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ch_valid) begin
               if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
                  idx_d   = cell_addr(row_q, col_q, COLS);
                  char_d  = ch_data;
                  bs_d    = 1'b0;
                  state_d = S_WRITE;
               end else if (ch_data == CH_LF) begin
                  if (row_q == LAST_ROW) begin
                     idx_d   = ROW1_BASE;
                     state_d = S_SCR_RD;
                  end else begin
                     col_d = '0;
                     row_d = row_q + 5'd1;
                  end
               end else if (ch_data == CH_CR) begin
                  col_d = '0;
               end else if (ch_data == CH_BS && col_q != '0) begin
                  idx_d   = cell_addr(row_q, col_q - 7'd1, COLS);
                  char_d  = BLANK;
                  bs_d    = 1'b1;
                  state_d = S_WRITE;
               end else if (ch_data == CH_FF) begin
                  idx_d   = '0;
                  state_d = S_CLEAR;
               end
            end
         end
         S_WRITE: begin
            if (xfer_done) begin
               state_d = S_IDLE;
               if (bs_q) begin
                  col_d = col_q - 7'd1;
               end else if (col_q != LAST_COL) begin
                  col_d = col_q + 7'd1;
               end else if (row_q != LAST_ROW) begin
                  col_d = '0;
                  row_d = row_q + 5'd1;
               end else begin
                  // Wrap on the bottom row: cursor stays put until the scroll ends.
                  idx_d   = ROW1_BASE;
                  state_d = S_SCR_RD;
               end
            end
         end
         S_SCR_RD: begin
            if (xfer_done) state_d = S_SCR_WR;
         end
         S_SCR_WR: begin
            if (xfer_done) begin
               if (idx_q == LAST_CELL) begin
                  idx_d   = LAST_ROW_BASE;
                  state_d = S_SCR_FILL;
               end else begin
                  idx_d   = idx_q + 12'd1;
                  state_d = S_SCR_RD;
               end
            end
         end
         S_SCR_FILL: begin
            if (xfer_done) begin
               if (idx_q == LAST_CELL) begin
                  col_d   = '0;
                  row_d   = LAST_ROW;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 12'd1;
               end
            end
         end
         S_CLEAR: begin
            if (xfer_done) begin
               if (idx_q == LAST_CELL) begin
                  col_d   = '0;
                  row_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  idx_d = idx_q + 12'd1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ch_ready   = (state_q == S_IDLE);
      busy       = (state_q != S_IDLE);
      xfer_start = (state_q != S_IDLE) && !issued_q;
      xfer_we    = (state_q != S_SCR_RD);
      xfer_addr  = (state_q == S_SCR_WR) ? (idx_q - ROW1_BASE) : idx_q;
      case (state_q)
         S_WRITE:  xfer_wdata = {ATTR, char_q};
         S_SCR_WR: xfer_wdata = xfer_rdata;
         default:  xfer_wdata = {ATTR, BLANK};
      endcase
      cur_col = col_q;
      cur_row = row_q;
   end

endmodule
